// File: rtl/alu_shift_sequencer_if.sv
// Bundles the microcode request, the ALU drive and the completion signals
// of the shift/rotate sequencer.
interface alu_shift_sequencer_if;
    logic        start;
    logic [2:0]  func;
    logic        bit16;
    logic [15:0] operand;
    logic [7:0]  count;
    logic [11:0] flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [11:0] flags_out;
    logic [3:0]  alu_func;
    logic [15:0] alu_op1;
    logic        alu_bit16;
    logic [11:0] alu_flags;
    logic [15:0] alu_result;

    // master: sequencer plus shared ALU; slave: the shift controller
    modport master (
        output start, func, bit16, operand, count, flags_in, alu_result,
        input  busy, done, result, flags_out, alu_func, alu_op1, alu_bit16, alu_flags
    );

    modport slave (
        input  start, func, bit16, operand, count, flags_in, alu_result,
        output busy, done, result, flags_out, alu_func, alu_op1, alu_bit16, alu_flags
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// x86 shift/rotate-by-count controller: steps the shared ALU one bit per clock,
// tracking CF and assembling OF/SF/ZF/PF into the 12-bit FLAGS image.
module alu_shift_sequencer #(
    parameter bit MASK_COUNT = 1'b1
) (
    input  logic                       clock,
    input  logic                       resetn,
    alu_shift_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  func_q;
    logic        bit16_q;
    logic [11:0] flags_q;
    logic [15:0] work_q;
    logic [15:0] orig_q;
    logic        carry_q;
    logic [7:0]  remaining_q;
    logic [15:0] result_q;
    logic [11:0] flags_out_q;

    logic [7:0]  eff_count;
    logic        last_step;
    logic        step_carry;
    logic [15:0] fin;
    logic        fin_msb, fin_msb1, orig_msb, of_bit;
    logic [11:0] flags_fin;

    assign eff_count = MASK_COUNT ? {3'b000, bus.count[4:0]} : bus.count;
    assign last_step = (remaining_q <= 8'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = (eff_count == 8'd0) ? S_DONE : S_RUN;
            S_RUN:  if (last_step) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == S_RUN);
        bus.done     = (state_q == S_DONE);
        bus.alu_func = (state_q == S_RUN) ? {1'b1, func_q} : 4'h0;
    end

    // Left-moving ops (even func codes) shift out the msb, right-moving ones bit0
    always_comb begin
        step_carry = func_q[0] ? work_q[0] : (bit16_q ? work_q[15] : work_q[7]);
        fin        = bit16_q ? bus.alu_result : {orig_q[15:8], bus.alu_result[7:0]};
        fin_msb    = bit16_q ? fin[15] : fin[7];
        fin_msb1   = bit16_q ? fin[14] : fin[6];
        orig_msb   = bit16_q ? orig_q[15] : orig_q[7];
        unique case (func_q)
            3'd1, 3'd3: of_bit = fin_msb ^ fin_msb1;
            3'd5:       of_bit = orig_msb;
            3'd7:       of_bit = 1'b0;
            default:    of_bit = step_carry ^ fin_msb;
        endcase
        flags_fin     = flags_q;
        flags_fin[0]  = step_carry;
        flags_fin[11] = of_bit;
        if (func_q[2]) begin
            flags_fin[7] = fin_msb;
            flags_fin[6] = bit16_q ? (fin == 16'h0000) : (fin[7:0] == 8'h00);
            flags_fin[2] = ~^fin[7:0];
        end
        flags_fin[1] = 1'b1;
        flags_fin[3] = 1'b0;
        flags_fin[5] = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            func_q      <= '0;
            bit16_q     <= 1'b0;
            flags_q     <= '0;
            work_q      <= '0;
            orig_q      <= '0;
            carry_q     <= 1'b0;
            remaining_q <= '0;
            result_q    <= '0;
            flags_out_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        func_q      <= bus.func;
                        bit16_q     <= bus.bit16;
                        flags_q     <= bus.flags_in;
                        work_q      <= bus.operand;
                        orig_q      <= bus.operand;
                        carry_q     <= bus.flags_in[0];
                        remaining_q <= eff_count;
                        if (eff_count == 8'd0) begin
                            result_q    <= bus.operand;
                            flags_out_q <= bus.flags_in;
                        end
                    end
                end
                S_RUN: begin
                    work_q      <= bus.alu_result;
                    carry_q     <= step_carry;
                    remaining_q <= remaining_q - 8'd1;
                    if (last_step) begin
                        result_q    <= fin;
                        flags_out_q <= flags_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.flags_out = flags_out_q;
    assign bus.alu_op1   = work_q;
    assign bus.alu_bit16 = bit16_q;
    assign bus.alu_flags = {flags_q[11:1], carry_q};

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural single-step ALU.
module tb_alu_shift_sequencer;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    alu_shift_sequencer_if bus ();

    alu_shift_sequencer #(.MASK_COUNT(1'b1)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Shared ALU: one-bit shift/rotate of alu_op1, byte ops keep [15:8]
    logic [15:0] a16, r16;
    logic [7:0]  a8, r8;
    logic        cin;
    always_comb begin
        a16 = bus.alu_op1;
        a8  = a16[7:0];
        cin = bus.alu_flags[0];
        r16 = a16;
        r8  = a8;
        case (bus.alu_func)
            4'h8: begin r16 = {a16[14:0], a16[15]}; r8 = {a8[6:0], a8[7]}; end
            4'h9: begin r16 = {a16[0], a16[15:1]};  r8 = {a8[0], a8[7:1]};  end
            4'hA: begin r16 = {a16[14:0], cin};     r8 = {a8[6:0], cin};    end
            4'hB: begin r16 = {cin, a16[15:1]};     r8 = {cin, a8[7:1]};    end
            4'hC, 4'hE: begin r16 = {a16[14:0], 1'b0}; r8 = {a8[6:0], 1'b0}; end
            4'hD: begin r16 = {1'b0, a16[15:1]};    r8 = {1'b0, a8[7:1]};   end
            4'hF: begin r16 = {a16[15], a16[15:1]}; r8 = {a8[7], a8[7:1]};  end
            default: ;
        endcase
        bus.alu_result = bus.alu_bit16 ? r16 : {a16[15:8], r8};
    end

    typedef struct {
        string       name;
        logic [2:0]  func;
        logic        bit16;
        logic [15:0] op;
        logic [7:0]  cnt;
        logic [11:0] fl;
        logic [15:0] eres;
        logic [11:0] efl;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit pulse_mid);
        int  k;
        int  busy_n;
        bit  got;
        logic [3:0] seen_func;
        @(negedge clock);
        bus.func     = v.func;
        bus.bit16    = v.bit16;
        bus.operand  = v.op;
        bus.count    = v.cnt;
        bus.flags_in = v.fl;
        bus.start    = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        k = 0; busy_n = 0; got = 1'b0; seen_func = 4'h0;
        while (!got && k < 100) begin
            @(negedge clock);
            k++;
            if (bus.busy) busy_n++;
            if (k == 1) seen_func = bus.alu_func;
            if (bus.done) got = 1'b1;
            if (pulse_mid && k == 2) begin
                bus.start   = 1'b1;
                bus.operand = 16'h00FF;
                bus.count   = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk($sformatf("%s done_seen", v.name), got, 1);
        chk($sformatf("%s result", v.name), bus.result, v.eres);
        chk($sformatf("%s flags", v.name), bus.flags_out, v.efl);
        chk($sformatf("%s latency", v.name), k, v.lat);
        chk($sformatf("%s busy_cycles", v.name), busy_n, v.lat - 1);
        chk($sformatf("%s alu_func", v.name), seen_func, (v.lat > 1) ? {1'b1, v.func} : 4'h0);
        @(negedge clock);
        chk($sformatf("%s done_pulse_width", v.name), bus.done, 0);
        chk($sformatf("%s result_held", v.name), bus.result, v.eres);
    endtask

    initial begin
        int  n;
        bit  saw;
        vecs[0]  = '{"shl8_81",    3'd4, 1'b0, 16'h0081, 8'h01, 12'h002, 16'h0002, 12'h803, 2};
        vecs[1]  = '{"ror16_4",    3'd1, 1'b1, 16'h0001, 8'h04, 12'h0C5, 16'h1000, 12'h0C6, 5};
        vecs[2]  = '{"rcl8_9",     3'd2, 1'b0, 16'h0080, 8'h09, 12'h000, 16'h0080, 12'h802, 10};
        vecs[3]  = '{"shr16_m21",  3'd5, 1'b1, 16'h0004, 8'h21, 12'h710, 16'h0002, 12'h712, 2};
        vecs[4]  = '{"shr16_m20",  3'd5, 1'b1, 16'h0004, 8'h20, 12'h8D5, 16'h0004, 12'h8D5, 1};
        vecs[5]  = '{"shl8_hi",    3'd4, 1'b0, 16'hAB81, 8'h01, 12'h000, 16'hAB02, 12'h803, 2};
        vecs[6]  = '{"rol8_force", 3'd0, 1'b0, 16'h0081, 8'h01, 12'h028, 16'h0003, 12'h803, 2};
        vecs[7]  = '{"rcr16_1",    3'd3, 1'b1, 16'h0001, 8'h01, 12'h001, 16'h8000, 12'h803, 2};
        vecs[8]  = '{"shl16_zero", 3'd4, 1'b1, 16'h8000, 8'h01, 12'h000, 16'h0000, 12'h847, 2};
        vecs[9]  = '{"sal8_40",    3'd6, 1'b0, 16'h0040, 8'h01, 12'h000, 16'h0080, 12'h882, 2};
        vecs[10] = '{"ror8_mE5",   3'd1, 1'b0, 16'h0001, 8'hE5, 12'h0C4, 16'h0008, 12'h0C6, 6};
        vecs[11] = '{"sar16_2",    3'd7, 1'b1, 16'h8001, 8'h02, 12'h000, 16'hE000, 12'h086, 3};

        bus.start = 1'b0; bus.func = '0; bus.bit16 = 1'b0;
        bus.operand = '0; bus.count = '0; bus.flags_in = '0;

        #3;
        chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.flags_out, bus.alu_func,
                              bus.alu_op1, bus.alu_bit16, bus.alu_flags}, 64'h0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

        // SAR with a stray start during RUN: ignored and not queued
        run_vec('{"sar8_ignore", 3'd7, 1'b0, 16'h0080, 8'h03, 12'h000, 16'h00F0, 12'h086, 4}, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        chk("ignored_start_not_queued", saw, 0);

        // Reset mid-operation
        @(negedge clock);
        bus.func = 3'd0; bus.bit16 = 1'b1; bus.operand = 16'h1234;
        bus.count = 8'd10; bus.flags_in = 12'h000; bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_outputs", {bus.busy, bus.done, bus.result, bus.flags_out, bus.alu_func,
                                    bus.alu_op1, bus.alu_bit16, bus.alu_flags}, 64'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        saw = 1'b0;
        n = 0;
        while (n < 15) begin
            @(negedge clock);
            n++;
            if (bus.done) saw = 1'b1;
        end
        chk("abandoned_no_done", saw, 0);
        run_vec(vecs[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Multi-cycle controller that performs x86 shift/rotate-by-count (ROL/ROR/RCL/RCR/SHL/SHR/SAL/SAR with CL or imm8 count). It drives the shared combinational ALU one single-bit step per clock, feeding each result back as the next operand. It tracks CF through the iterations and assembles final OF/SF/ZF/PF in the 12-bit FLAGS layout. It sits between the microcode sequencer and the ALU. While busy it owns the ALU input ports.

Parameters:
MASK_COUNT, 1, 1: count is masked to count[4:0] (286+ behaviour); 0: full 8-bit count (8086 behaviour).

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
func  input  3  shift type: 0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SAL, 7 SAR
bit16  input  1  1 = 16-bit operand, 0 = 8-bit (bits [15:8] pass through unchanged)
operand  input  16  value to shift
count  input  8  shift count
flags_in  input  12  current FLAGS (OF11 DF10 IF9 TF8 SF7 ZF6 AF4 PF2 CF0)
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result/flags_out are valid
result  output  16  final value, held until next accepted start
flags_out  output  12  final FLAGS, held until next accepted start
alu_func  output  4  ALU op code = {1'b1, func}; 0 in IDLE/DONE
alu_op1  output  16  current working value
alu_bit16  output  1  latched bit16
alu_flags  output  12  latched flags with bit0 replaced by working carry
alu_result  input  16  combinational ALU result, same cycle

Behaviour:
- Reset (async, resetn low): state IDLE; busy=0, done=0, result=0, flags_out=0, alu_func=0, alu_op1=0, alu_bit16=0, alu_flags=0. Reset during RUN abandons the operation; no done pulse.
- States: IDLE -> RUN (start, effective count != 0); IDLE -> DONE (start, effective count == 0); RUN -> RUN while remaining > 1; RUN -> DONE after last step; DONE -> IDLE unconditionally.
- On accepted start: latch func, bit16, flags_in, operand into work, CF into carry. remaining = MASK_COUNT ? count[4:0] : count.
- RUN, each cycle: work <= alu_result. carry <= bit shifted out: ROL/RCL/SHL/SAL take old work msb (bit15 or bit7); ROR/RCR/SHR/SAR take old work bit0. remaining decrements.
- RCL/RCR iterate through the carry naturally. Count 9 (8-bit) or 17 (16-bit) restores the operand. No modulo shortcut.
- Latency: effective count N>0 gives done N+1 cycles after the start edge; N=0 gives done 1 cycle after.
- N=0: result = operand, flags_out = flags_in unchanged.
- N>0 flags: CF = carry. msb is the top bit of the final result at the operand width.
  - OF for ROL/RCL/SHL/SAL = CF ^ msb.
  - OF for ROR/RCR = msb ^ msb-1.
  - OF for SHR = msb of original operand.
  - OF for SAR = 0.
- Shifts (func 4-7) also update SF, ZF and PF (PF = even parity of result[7:0]). Rotates leave SF/ZF/PF unchanged.
- AF, DF, IF, TF are copied from the latched flags. Bit1 is forced to 1; bits 3 and 5 are forced to 0.
- 8-bit mode: result[15:8] = operand[15:8].
- start asserted while busy or in DONE is ignored, not queued.
- done is high only in the DONE cycle. result and flags_out are registered on entry to DONE.

Test Plan:
- SHL 8-bit, operand 0x0081, count 1, flags_in 0x002 -> done at T+2, result 0x0002, CF=1, OF=1, SF=0, ZF=0, PF=0.
- ROR 16-bit, operand 0x0001, count 4 -> busy for 4 cycles, done at T+5, result 0x1000, CF=0, OF=0, SF/ZF/PF equal to flags_in.
- RCL 8-bit, operand 0x0080, CF=0, count 9 -> result 0x0080, CF=0, done at T+10.
- SAR 8-bit, operand 0x0080, count 3 -> result 0x00F0, CF=0, SF=1, ZF=0, PF=1, OF=0. Second start pulsed during RUN is ignored.
- MASK_COUNT=1, SHR 16-bit, operand 0x0004, count 0x21 -> effective count 1, result 0x0002, done at T+2. Count 0x20 -> done at T+1, flags_out = flags_in, result = operand.
- ROL 16-bit, count 10; drop resetn at T+4 -> all outputs 0 immediately, no done pulse. A new start after release runs normally.
